dut_access_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port bit-register DUT between two requesters (req index 0 and 1). It accepts one read or write command at a time and sequences it onto the DUT write/read method ports, honouring the rdy signals. It returns a one-cycle response, carrying read data or an error, to the requester that owned the command. It sits between the two bus masters and the DUT, in the same CLK domain.

---
 rtl/dut_access_arbiter.sv | 129 ++++++++++++
 tb/tb_dut_access_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_access_arbiter.sv
// rtl/dut_access_arbiter.sv - round-robin arbiter sharing a single-port bit-register DUT between two requesters
module dut_access_arbiter #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 1,
    parameter int WAIT_MAX = 15
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            resp_valid,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic [ADDR_W-1:0]     write_address,
    output logic [DATA_W-1:0]     write_data,
    output logic                  write_en,
    input  logic                  write_rdy,
    output logic [ADDR_W-1:0]     read_address,
    output logic                  read_en,
    input  logic [DATA_W-1:0]     read_data,
    input  logic                  read_rdy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t              state_q;
    logic                last_grant_q;
    logic [7:0]          wait_q;
    logic                owner_q;
    logic                cmd_write_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_wdata_q;
    logic [1:0]          resp_valid_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                resp_err_q;

    logic                win;
    logic                accept;
    logic                issue;
    logic                cur_rdy;
    logic                timeout;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [1:0]          owner_onehot;
    logic [7:0]          wait_d;

    always_comb begin
        // On a tie the requester that did not win last time gets the slot.
        win          = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        accept       = (state_q == IDLE) && (|req_valid) && !RST_N;
        req_ready    = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
        sel_write    = win ? req_write[1] : req_write[0];
        sel_addr     = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        sel_wdata    = win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        issue        = (state_q == ISSUE) && !RST_N;
        cur_rdy      = cmd_write_q ? write_rdy : read_rdy;
        write_en     = issue && cmd_write_q && write_rdy;
        read_en      = issue && !cmd_write_q && read_rdy;
        timeout      = issue && !cur_rdy && (wait_q == WAIT_LAST);
        owner_onehot = owner_q ? 2'b10 : 2'b01;
        wait_d       = wait_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wait_q       <= 8'd0;
            owner_q      <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q      <= win;
                        cmd_write_q  <= sel_write;
                        cmd_addr_q   <= sel_addr;
                        cmd_wdata_q  <= sel_wdata;
                        last_grant_q <= win;
                        wait_q       <= 8'd0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (write_en || read_en) begin
                        resp_valid_q <= owner_onehot;
                        resp_data_q  <= cmd_write_q ? '0 : read_data;
                        resp_err_q   <= 1'b0;
                        state_q      <= RESP;
                    end else if (timeout) begin
                        resp_valid_q <= owner_onehot;
                        resp_data_q  <= '0;
                        resp_err_q   <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                RESP: begin
                    resp_valid_q <= 2'b00;
                    resp_data_q  <= '0;
                    resp_err_q   <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Everything is forced quiet in any cycle reset is high, even before the first reset edge.
    assign resp_valid    = RST_N ? 2'b00 : resp_valid_q;
    assign resp_data     = RST_N ? '0 : resp_data_q;
    assign resp_err      = RST_N ? 1'b0 : resp_err_q;
    assign write_address = RST_N ? '0 : cmd_addr_q;
    assign write_data    = RST_N ? '0 : cmd_wdata_q;
    assign read_address  = RST_N ? '0 : cmd_addr_q;

endmodule

// File: tb/tb_dut_access_arbiter.sv
// tb/tb_dut_access_arbiter.sv - directed table and sequence checks for dut_access_arbiter
module tb_dut_access_arbiter;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [1:0] req_valid, req_ready, req_write, req_wdata, resp_valid;
    logic [5:0] req_addr;
    logic       resp_data, resp_err;
    logic [2:0] write_address, read_address;
    logic       write_data, write_en, write_rdy, read_en, read_data, read_rdy;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    dut_access_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .write_address(write_address), .write_data(write_data), .write_en(write_en),
        .write_rdy(write_rdy), .read_address(read_address), .read_en(read_en),
        .read_data(read_data), .read_rdy(read_rdy)
    );

    typedef struct {
        logic       rst;
        logic [1:0] vld;
        logic [1:0] wr;
        logic [5:0] addr;
        logic [1:0] wdata;
        logic       wrdy;
        logic       rrdy;
        logic       rdata;
        logic [1:0] e_ready;
        logic       e_wen;
        logic       e_ren;
        logic [2:0] e_waddr;
        logic [2:0] e_raddr;
        logic       e_wdata;
        logic [1:0] e_rvalid;
        logic       e_rdata;
        logic       e_rerr;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] vld, input logic [1:0] wr,
                         input logic [5:0] addr, input logic [1:0] wd,
                         input logic wrdy, input logic rrdy, input logic rdata);
        RST_N     = rst;
        req_valid = vld;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        write_rdy = wrdy;
        read_rdy  = rrdy;
        read_data = rdata;
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_cycle(input logic rst);
        drive(rst, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        next_cycle();
    endtask

    task automatic do_reset;
        idle_cycle(1'b1);
        idle_cycle(1'b0);
    endtask

    initial begin
        int grant_idx [6];
        int grant_cyc [6];
        int ng;
        int wen_seen;
        int rv_seen;

        vecs[0]  = '{1'b1, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'b01, 2'b01, 6'o05, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd5, 3'd0, 1'b1, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 2'b00, 6'o50, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b10, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'b11, 2'b01, 6'o27, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 2'b11, 2'b01, 6'o27, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 3'd7, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 2'b11, 2'b01, 6'o27, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 2'b01, 6'o27, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b10, 1'b0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].wrdy, vecs[i].rrdy, vecs[i].rdata);
            @(negedge CLK);
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d write_en", i), 32'(write_en), 32'(vecs[i].e_wen));
            chk($sformatf("v%0d read_en", i), 32'(read_en), 32'(vecs[i].e_ren));
            chk($sformatf("v%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rvalid));
            chk($sformatf("v%0d resp_data", i), 32'(resp_data), 32'(vecs[i].e_rdata));
            chk($sformatf("v%0d resp_err", i), 32'(resp_err), 32'(vecs[i].e_rerr));
            if (vecs[i].e_wen) begin
                chk($sformatf("v%0d write_address", i), 32'(write_address), 32'(vecs[i].e_waddr));
                chk($sformatf("v%0d write_data", i), 32'(write_data), 32'(vecs[i].e_wdata));
            end
            if (vecs[i].e_ren)
                chk($sformatf("v%0d read_address", i), 32'(read_address), 32'(vecs[i].e_raddr));
            next_cycle();
        end

        // Contention: both requesters saturating from reset release.
        drive(1'b1, 2'b11, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        next_cycle();
        drive(1'b0, 2'b11, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0);
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge CLK);
            if (req_ready != 2'b00) begin
                grant_idx[ng] = (req_ready == 2'b10) ? 1 : 0;
                grant_cyc[ng] = c;
                ng++;
            end
            next_cycle();
        end
        chk("contention grant count", 32'(ng), 32'd6);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("contention grant %0d owner", i), 32'(grant_idx[i]), 32'(i % 2));
            if (i > 0)
                chk($sformatf("contention grant %0d spacing", i), 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd3);
        end

        // Stall: read of addr 2 with read_rdy low for 4 cycles.
        do_reset();
        drive(1'b0, 2'b01, 2'b00, 6'o02, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("stall accept", 32'(req_ready), 32'd1);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b0, 1'b1);
            @(negedge CLK);
            chk($sformatf("stall %0d read_en", k), 32'(read_en), 32'd0);
            chk($sformatf("stall %0d resp_valid", k), 32'(resp_valid), 32'd0);
            next_cycle();
        end
        drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        chk("stall release read_en", 32'(read_en), 32'd1);
        chk("stall release read_address", 32'(read_address), 32'd2);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk("stall resp_valid", 32'(resp_valid), 32'd1);
        chk("stall resp_data", 32'(resp_data), 32'd1);
        chk("stall resp_err", 32'(resp_err), 32'd0);
        chk("stall read_en after", 32'(read_en), 32'd0);
        next_cycle();

        // Timeout: requester 1 write with write_rdy stuck low.
        do_reset();
        drive(1'b0, 2'b10, 2'b10, 6'o30, 2'b10, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("timeout accept", 32'(req_ready), 32'd2);
        next_cycle();
        wen_seen = 0;
        rv_seen  = 0;
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b0, 1'b1, 1'b0);
            @(negedge CLK);
            if (write_en) wen_seen++;
            if (resp_valid != 2'b00) rv_seen++;
            next_cycle();
        end
        chk("timeout write_en cycles", 32'(wen_seen), 32'd0);
        chk("timeout early resp", 32'(rv_seen), 32'd0);
        @(negedge CLK);
        chk("timeout resp_valid", 32'(resp_valid), 32'd2);
        chk("timeout resp_err", 32'(resp_err), 32'd1);
        chk("timeout resp_data", 32'(resp_data), 32'd0);
        chk("timeout write_en", 32'(write_en), 32'd0);
        next_cycle();
        drive(1'b0, 2'b01, 2'b00, 6'o01, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk("post-timeout accept", 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk("post-timeout read_en", 32'(read_en), 32'd1);
        next_cycle();
        @(negedge CLK);
        chk("post-timeout resp_err", 32'(resp_err), 32'd0);
        chk("post-timeout resp_valid", 32'(resp_valid), 32'd1);
        next_cycle();

        // Reset while a read is stalled in ISSUE.
        do_reset();
        drive(1'b0, 2'b01, 2'b00, 6'o04, 2'b00, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        chk("rst-mid accept", 32'(req_ready), 32'd1);
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b0, 1'b0);
            @(negedge CLK);
            next_cycle();
        end
        drive(1'b1, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        chk("rst-mid read_en", 32'(read_en), 32'd0);
        chk("rst-mid resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        chk("rst-after read_en", 32'(read_en), 32'd0);
        chk("rst-after resp_valid", 32'(resp_valid), 32'd0);
        next_cycle();
        drive(1'b0, 2'b11, 2'b00, 6'o64, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk("rst-after tie grant", 32'(req_ready), 32'd1);
        next_cycle();
        drive(1'b0, 2'b00, 2'b00, 6'o00, 2'b00, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        chk("rst-after read_en", 32'(read_en), 32'd1);
        chk("rst-after read_address", 32'(read_address), 32'd4);
        next_cycle();
        @(negedge CLK);
        chk("rst-after resp owner", 32'(resp_valid), 32'd1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
